// File: rtl/control_pkg.sv
// ============================================================================
// Module      : control_pkg
// Description : Shared types and encodings for the multi-cycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_pkg;

    typedef enum logic [1:0] {
        FETCH     = 2'b00,
        DECODE    = 2'b01,
        EXECUTE   = 2'b10,
        WRITEBACK = 2'b11
    } ctrlState_t;

    typedef enum logic [3:0] {
        CLS_NOP   = 4'd0,
        CLS_RTYPE = 4'd1,
        CLS_IMM_S = 4'd2,
        CLS_IMM_Z = 4'd3,
        CLS_LUI   = 4'd4,
        CLS_LOAD  = 4'd5,
        CLS_STOR  = 4'd6,
        CLS_JCOND = 4'd7,
        CLS_BCOND = 4'd8
    } instrClass_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [2:0] IMM_RAW  = 3'd0;
    localparam logic [2:0] IMM_SEXT = 3'd1;
    localparam logic [2:0] IMM_ZEXT = 3'd2;
    localparam logic [2:0] IMM_ONE  = 3'd3;

endpackage

`default_nettype wire

// File: rtl/instr_classifier.sv
// ============================================================================
// Module      : instr_classifier
// Description : Combinational opcode/extension to instruction-class decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_classifier
    import control_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  ext,
    output instrClass_t instrClass,
    output logic        isCompare
);

    always_comb begin
        instrClass = CLS_NOP;
        case (opcode)
            OP_RTYPE:                     instrClass = CLS_RTYPE;
            OP_ADDI, OP_SUBI, OP_CMPI:    instrClass = CLS_IMM_S;
            OP_ANDI, OP_ORI, OP_XORI,
            OP_MOVI:                      instrClass = CLS_IMM_Z;
            OP_LUI:                       instrClass = CLS_LUI;
            OP_BCOND:                     instrClass = CLS_BCOND;
            OP_MEM: begin
                case (ext)
                    EXT_LOAD:  instrClass = CLS_LOAD;
                    EXT_STOR:  instrClass = CLS_STOR;
                    EXT_JCOND: instrClass = CLS_JCOND;
                    default:   instrClass = CLS_NOP;
                endcase
            end
            default:                      instrClass = CLS_NOP;
        endcase
    end

    // Compares update flags but never write the register file.
    assign isCompare = ((opcode == OP_RTYPE) && (ext == EXT_CMP)) || (opcode == OP_CMPI);

endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
// Module      : control_fsm
// Description : FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the 16-bit
//               datapath. Optional memory timeout: CTRL_MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_fsm
    import control_pkg::*;
`ifdef CTRL_MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        memReady,
    input  logic        condTrue,
    input  logic        halt,
    output logic [1:0]  currentState,
    output logic        irLoad,
    output logic        pcEnable,
    output logic        pcSelect,
    output logic        regWriteEnable,
    output logic        psrLoad,
    output logic        memRequest,
    output logic        memWrite,
    output logic        regNormExtendCtl,
    output logic        reg2OrImmediateCtl,
    output logic        pcOrReg1Ctl,
    output logic [2:0]  immediateSelectCtl
`ifdef CTRL_MEM_TIMEOUT_EN
    ,
    output logic        fault
`endif
);

    ctrlState_t  r_state;
    ctrlState_t  w_nextState;
    instrClass_t r_class;
    instrClass_t w_decodedClass;
    logic        r_isCompare;
    logic        w_decodedCompare;
    logic        r_memPhase;
    logic        w_nextMemPhase;
    logic        w_timeout;
    logic        w_faulted;
    logic        w_selPcOrReg1;
    logic        w_selReg2OrImm;
    logic [2:0]  w_selImm;
    logic        w_unusedIrBits;

    assign w_unusedIrBits = ^{instruction[11:8], instruction[3:0]};

    instr_classifier u_classifier (
        .opcode     (instruction[15:12]),
        .ext        (instruction[7:4]),
        .instrClass (w_decodedClass),
        .isCompare  (w_decodedCompare)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= FETCH;
            r_class     <= CLS_NOP;
            r_isCompare <= 1'b0;
            r_memPhase  <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_state    <= FETCH;
                r_memPhase <= 1'b0;
            end else begin
                r_state    <= w_nextState;
                r_memPhase <= w_nextMemPhase;
            end
            if (r_state == DECODE) begin
                r_class     <= w_decodedClass;
                r_isCompare <= w_decodedCompare;
            end
        end
    end

    // Operand selects per class, shared by EXECUTE and WRITEBACK.
    always_comb begin
        w_selPcOrReg1  = 1'b0;
        w_selReg2OrImm = 1'b0;
        w_selImm       = IMM_RAW;
        case (r_class)
            CLS_RTYPE: w_selPcOrReg1 = 1'b1;
            CLS_IMM_S: begin
                w_selPcOrReg1  = 1'b1;
                w_selReg2OrImm = 1'b1;
                w_selImm       = IMM_SEXT;
            end
            CLS_IMM_Z: begin
                w_selPcOrReg1  = 1'b1;
                w_selReg2OrImm = 1'b1;
                w_selImm       = IMM_ZEXT;
            end
            CLS_LUI: begin
                w_selPcOrReg1  = 1'b1;
                w_selReg2OrImm = 1'b1;
                w_selImm       = IMM_RAW;
            end
            CLS_BCOND: begin
                w_selReg2OrImm = 1'b1;
                w_selImm       = IMM_SEXT;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_nextState        = r_state;
        w_nextMemPhase     = r_memPhase;
        irLoad             = 1'b0;
        pcEnable           = 1'b0;
        pcSelect           = 1'b0;
        regWriteEnable     = 1'b0;
        psrLoad            = 1'b0;
        memRequest         = 1'b0;
        memWrite           = 1'b0;
        regNormExtendCtl   = 1'b0;
        reg2OrImmediateCtl = 1'b0;
        pcOrReg1Ctl        = 1'b0;
        immediateSelectCtl = IMM_RAW;

        case (r_state)
            FETCH: begin
                if (!halt && !w_faulted) begin
                    memRequest         = 1'b1;
                    reg2OrImmediateCtl = 1'b1;
                    immediateSelectCtl = IMM_ONE;
                    if (memReady) begin
                        irLoad      = 1'b1;
                        pcEnable    = 1'b1;
                        w_nextState = DECODE;
                    end
                end
            end
            DECODE: w_nextState = EXECUTE;
            EXECUTE: begin
                pcOrReg1Ctl        = w_selPcOrReg1;
                reg2OrImmediateCtl = w_selReg2OrImm;
                immediateSelectCtl = w_selImm;
                case (r_class)
                    // First cycle forms the address; the request follows.
                    CLS_LOAD, CLS_STOR: begin
                        if (!r_memPhase) begin
                            w_nextMemPhase = 1'b1;
                        end else begin
                            memRequest = 1'b1;
                            memWrite   = (r_class == CLS_STOR);
                            if (memReady) begin
                                w_nextMemPhase = 1'b0;
                                w_nextState    = WRITEBACK;
                            end
                        end
                    end
                    CLS_BCOND, CLS_JCOND: begin
                        pcEnable    = condTrue;
                        pcSelect    = condTrue;
                        w_nextState = WRITEBACK;
                    end
                    default: w_nextState = WRITEBACK;
                endcase
            end
            WRITEBACK: begin
                pcOrReg1Ctl        = w_selPcOrReg1;
                reg2OrImmediateCtl = w_selReg2OrImm;
                immediateSelectCtl = w_selImm;
                case (r_class)
                    CLS_RTYPE, CLS_IMM_S: begin
                        regWriteEnable = !r_isCompare;
                        psrLoad        = 1'b1;
                    end
                    CLS_IMM_Z: begin
                        regWriteEnable = 1'b1;
                        psrLoad        = 1'b1;
                    end
                    CLS_LUI, CLS_LOAD: regWriteEnable = 1'b1;
                    default: ;
                endcase
                w_nextState = FETCH;
            end
            default: w_nextState = FETCH;
        endcase

        // Outputs go quiet the instant reset is asserted.
        if (!reset) begin
            irLoad             = 1'b0;
            pcEnable           = 1'b0;
            pcSelect           = 1'b0;
            regWriteEnable     = 1'b0;
            psrLoad            = 1'b0;
            memRequest         = 1'b0;
            memWrite           = 1'b0;
            reg2OrImmediateCtl = 1'b0;
            pcOrReg1Ctl        = 1'b0;
            immediateSelectCtl = IMM_RAW;
        end
    end

    assign currentState = r_state;

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_waitCount;
    logic             r_fault;
    logic             w_waiting;

    assign w_waiting = memRequest && !memReady;
    assign w_timeout = w_waiting && (r_waitCount == LAST_WAIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_waitCount <= '0;
            r_fault     <= 1'b0;
        end else if (w_timeout) begin
            r_waitCount <= '0;
            r_fault     <= 1'b1;
        end else if (w_waiting) begin
            r_waitCount <= r_waitCount + 1'b1;
        end else begin
            r_waitCount <= '0;
        end
    end

    assign w_faulted = r_fault;
    assign fault     = r_fault;
`else
    assign w_timeout = 1'b0;
    assign w_faulted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// ============================================================================
// Module      : tb_control_fsm
// Description : Cycle-level scoreboard bench for control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_fsm;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic        memReady = 1'b0;
    logic        condTrue = 1'b0;
    logic        halt = 1'b0;
    logic [1:0]  currentState;
    logic        irLoad, pcEnable, pcSelect, regWriteEnable, psrLoad;
    logic        memRequest, memWrite, regNormExtendCtl;
    logic        reg2OrImmediateCtl, pcOrReg1Ctl;
    logic [2:0]  immediateSelectCtl;
`ifdef CTRL_MEM_TIMEOUT_EN
    logic        fault;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    // Vector: {state[14:13], ir, pe, ps, rw, psr, mr, mw, norm, r2i, pr1, imm[2:0]}
    localparam logic [14:0] M_CORE = 15'h7FC0;
    localparam logic [14:0] M_SEL  = 15'h001F;
    localparam logic [14:0] M_RP   = 15'h0018;
    localparam logic [14:0] M_RI   = 15'h0017;
    localparam logic [14:0] M_PI   = 15'h000F;
    localparam logic [14:0] M_ALL  = 15'h7FFF;

    typedef struct {
        string       tag;
        logic [14:0] vec;
        logic [14:0] mask;
    } expEntry_t;

    expEntry_t scoreboard[$];

`ifdef CTRL_MEM_TIMEOUT_EN
    control_fsm #(.TIMEOUT_CYCLES(8)) dut (
`else
    control_fsm dut (
`endif
        .clock              (clock),
        .reset              (reset),
        .instruction        (instruction),
        .memReady           (memReady),
        .condTrue           (condTrue),
        .halt               (halt),
        .currentState       (currentState),
        .irLoad             (irLoad),
        .pcEnable           (pcEnable),
        .pcSelect           (pcSelect),
        .regWriteEnable     (regWriteEnable),
        .psrLoad            (psrLoad),
        .memRequest         (memRequest),
        .memWrite           (memWrite),
        .regNormExtendCtl   (regNormExtendCtl),
        .reg2OrImmediateCtl (reg2OrImmediateCtl),
        .pcOrReg1Ctl        (pcOrReg1Ctl),
        .immediateSelectCtl (immediateSelectCtl)
`ifdef CTRL_MEM_TIMEOUT_EN
        ,
        .fault              (fault)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic checkResult(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [14:0] ev(input logic [1:0] st, input logic ir, input logic pe,
                                       input logic ps, input logic rw, input logic psr,
                                       input logic mr, input logic mw, input logic r2i,
                                       input logic pr1, input logic [2:0] imm);
        return {st, ir, pe, ps, rw, psr, mr, mw, 1'b0, r2i, pr1, imm};
    endfunction

    function automatic logic [14:0] observed();
        return {currentState, irLoad, pcEnable, pcSelect, regWriteEnable, psrLoad,
                memRequest, memWrite, regNormExtendCtl, reg2OrImmediateCtl, pcOrReg1Ctl,
                immediateSelectCtl};
    endfunction

    task automatic popCheck();
        expEntry_t e;
        if (scoreboard.size() == 0) begin
            checkResult("sb_empty", 32'd0, 32'd1);
        end else begin
            e = scoreboard.pop_front();
            checkResult(e.tag, {17'd0, observed() & e.mask}, {17'd0, e.vec & e.mask});
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
    task automatic cyc(input string tag, input logic rdy, input logic cnd, input logic hlt,
                       input logic [14:0] exp, input logic [14:0] mask);
        memReady = rdy;
        condTrue = cnd;
        halt     = hlt;
        scoreboard.push_back('{tag, exp, mask});
        @(negedge clock);
        popCheck();
        @(posedge clock);
        #1;
    endtask

    task automatic fetchHit(input string tag, input logic [15:0] instr);
        instruction = instr;
        cyc(tag, 1'b1, 1'b0, 1'b0, ev(2'd0,1,1,0,0,0,1,0,1,0,3'd3), M_CORE | M_SEL);
    endtask

    task automatic decodeCyc(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0, ev(2'd1,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);
    endtask

    initial begin
        #1;
        scoreboard.push_back('{"reset_state", 15'd0, M_ALL});
        popCheck();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // ADD: 4-cycle instruction, writes only in WRITEBACK
        fetchHit("add_fetch", 16'h0152);
        decodeCyc("add_decode");
        cyc("add_exec", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,0,1,3'd0), M_CORE | M_RP);
        cyc("add_wb",   0, 0, 0, ev(2'd3,0,0,0,1,1,0,0,0,1,3'd0), M_CORE | M_RP);

        // ADDI with one fetch wait cycle
        instruction = 16'h51FF;
        cyc("addi_fwait", 0, 0, 0, ev(2'd0,0,0,0,0,0,1,0,1,0,3'd3), M_CORE | M_SEL);
        fetchHit("addi_fetch", 16'h51FF);
        decodeCyc("addi_decode");
        cyc("addi_exec", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,1,0,3'd1), M_CORE | M_RI);
        cyc("addi_wb",   0, 0, 0, ev(2'd3,0,0,0,1,1,0,0,1,0,3'd1), M_CORE | M_RI);

        fetchHit("cmpi_fetch", 16'hB123);
        decodeCyc("cmpi_decode");
        cyc("cmpi_exec", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,1,0,3'd1), M_CORE | M_RI);
        cyc("cmpi_wb",   0, 0, 0, ev(2'd3,0,0,0,0,1,0,0,1,0,3'd1), M_CORE | M_RI);

        fetchHit("cmp_fetch", 16'h00B1);
        decodeCyc("cmp_decode");
        cyc("cmp_exec", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,0,1,3'd0), M_CORE | M_RP);
        cyc("cmp_wb",   0, 0, 0, ev(2'd3,0,0,0,0,1,0,0,0,1,3'd0), M_CORE | M_RP);

        fetchHit("andi_fetch", 16'h1234);
        decodeCyc("andi_decode");
        cyc("andi_exec", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,1,0,3'd2), M_CORE | M_RI);
        cyc("andi_wb",   0, 0, 0, ev(2'd3,0,0,0,1,1,0,0,1,0,3'd2), M_CORE | M_RI);

        fetchHit("lui_fetch", 16'hF012);
        decodeCyc("lui_decode");
        cyc("lui_exec", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,1,0,3'd0), M_CORE | M_RI);
        cyc("lui_wb",   0, 0, 0, ev(2'd3,0,0,0,1,0,0,0,1,0,3'd0), M_CORE | M_RI);

        // LOAD with memReady delayed 3 cycles: 8 cycles total
        fetchHit("load_fetch", 16'h4103);
        decodeCyc("load_decode");
        cyc("load_addr", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);
        for (int i = 0; i < 3; i++)
            cyc("load_wait", 0, 0, 0, ev(2'd2,0,0,0,0,0,1,0,0,0,3'd0), M_CORE);
        cyc("load_ready", 1, 0, 0, ev(2'd2,0,0,0,0,0,1,0,0,0,3'd0), M_CORE);
        cyc("load_wb",    0, 0, 0, ev(2'd3,0,0,0,1,0,0,0,0,0,3'd0), M_CORE);

        // STOR: memReady before the request must be ignored
        fetchHit("stor_fetch", 16'h4143);
        decodeCyc("stor_decode");
        cyc("stor_addr",  1, 0, 0, ev(2'd2,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);
        cyc("stor_ready", 1, 0, 0, ev(2'd2,0,0,0,0,0,1,1,0,0,3'd0), M_CORE);
        cyc("stor_wb",    0, 0, 0, ev(2'd3,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);

        fetchHit("bct_fetch", 16'hC0FE);
        decodeCyc("bct_decode");
        cyc("bct_exec", 0, 1, 0, ev(2'd2,0,1,1,0,0,0,0,1,0,3'd1), M_CORE | M_PI);
        cyc("bct_wb",   0, 0, 0, ev(2'd3,0,0,0,0,0,0,0,1,0,3'd1), M_CORE);

        fetchHit("bcf_fetch", 16'hC0FE);
        decodeCyc("bcf_decode");
        cyc("bcf_exec", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,1,0,3'd1), M_CORE | M_PI);
        cyc("bcf_wb",   0, 0, 0, ev(2'd3,0,0,0,0,0,0,0,1,0,3'd1), M_CORE);

        // JCOND: condTrue in WRITEBACK has no effect
        fetchHit("jc_fetch", 16'h40C5);
        decodeCyc("jc_decode");
        cyc("jc_exec", 0, 1, 0, ev(2'd2,0,1,1,0,0,0,0,0,0,3'd0), M_CORE | M_RP);
        cyc("jc_wb",   0, 1, 0, ev(2'd3,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);

        fetchHit("nop_fetch", 16'h7000);
        decodeCyc("nop_decode");
        cyc("nop_exec", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);
        cyc("nop_wb",   0, 0, 0, ev(2'd3,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);

        // Halt raised mid-instruction lets it retire, then holds FETCH
        fetchHit("hmid_fetch", 16'h0152);
        cyc("hmid_decode", 0, 0, 1, ev(2'd1,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);
        cyc("hmid_exec",   0, 0, 1, ev(2'd2,0,0,0,0,0,0,0,0,1,3'd0), M_CORE | M_RP);
        cyc("hmid_wb",     0, 0, 1, ev(2'd3,0,0,0,1,1,0,0,0,1,3'd0), M_CORE | M_RP);
        for (int i = 0; i < 2; i++)
            cyc("halt_hold", 1, 0, 1, ev(2'd0,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);

        // Reset asserted mid-EXECUTE of a LOAD
        fetchHit("rl_fetch", 16'h4103);
        decodeCyc("rl_decode");
        cyc("rl_addr", 0, 0, 0, ev(2'd2,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);
        cyc("rl_wait", 0, 0, 0, ev(2'd2,0,0,0,0,0,1,0,0,0,3'd0), M_CORE);
        reset = 1'b0;
        #1;
        scoreboard.push_back('{"rl_reset_now", 15'd0, M_ALL});
        popCheck();
        @(negedge clock);
        halt  = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++)
            cyc("rl_after", 1, 0, 1, ev(2'd0,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);

`ifdef CTRL_MEM_TIMEOUT_EN
        instruction = 16'h0152;
        for (int i = 0; i < 8; i++)
            cyc("to_wait", 0, 0, 0, ev(2'd0,0,0,0,0,0,1,0,1,0,3'd3), M_CORE | M_SEL);
        for (int i = 0; i < 3; i++) begin
            checkResult("to_fault", {31'd0, fault}, 32'd1);
            cyc("to_halted", 1, 0, 0, ev(2'd0,0,0,0,0,0,0,0,0,0,3'd0), M_CORE);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
